uart_link: RTL and testbench

//  Single-clock UART transmitter and receiver joined by an internal serial loopback line.
//  A byte is written into a TX holding buffer, then released onto the line by a start strobe.
//  The receiver deserialises the frame and presents the byte with a one-cycle valid pulse.

---
 rtl/uart_link_pkg.sv | 20 ++
 rtl/uart_link_rx.sv | 116 +++++++++++
 rtl/uart_link.sv | 103 ++++++++++
 tb/tb_uart_link.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/uart_link_pkg.sv
// Shared types and constants for the uart_link serial core (RX/TX state enums, line levels).
// The optional parity bit is enabled by defining UART_PARITY_EN.
package uart_link_pkg;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  // Counter width able to hold 0..value-1; never narrower than one bit.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/uart_link_rx.sv
// UART receiver: samples each bit mid-period, checks stop (and parity with UART_PARITY_EN).
// Presents data_rx with a one-cycle ready_rx pulse at the stop-bit sample point; no backpressure.
module uart_link_rx
  import uart_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              line,
  output logic              ready_rx,
  output logic [DATA_W-1:0] data_rx
);

  localparam int CNT_W = clog2(CLKS_PER_BIT);
  localparam int IDX_W = clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  rx_state_e         rx_state_q, rx_state_d;
  logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic [IDX_W-1:0]  rx_idx_q, rx_idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              perr_q, perr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              ready_q, ready_d;
  logic              mid, last;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    data_d     = data_q;
    ready_d    = 1'b0;
    mid        = (rx_cnt_q == CNT_HALF);
    last       = (rx_cnt_q == CNT_LAST);
    if (rx_state_q != RX_IDLE) rx_cnt_d = last ? '0 : rx_cnt_q + 1'b1;
    case (rx_state_q)
      RX_IDLE: if (line == START_LVL) begin
        perr_d   = 1'b0;
        rx_idx_d = '0;
        // With one clock per bit the detecting edge is already the start-bit sample.
        if (CLKS_PER_BIT == 1) begin
          rx_state_d = RX_DATA;
          rx_cnt_d   = '0;
        end else begin
          rx_state_d = RX_START;
          rx_cnt_d   = CNT_W'(1);
        end
      end
      RX_START: begin
        if (mid && line != START_LVL) begin
          rx_state_d = RX_IDLE;
          rx_cnt_d   = '0;
        end else if (last) begin
          rx_state_d = RX_DATA;
        end
      end
      RX_DATA: begin
        if (mid) shift_d = {line, shift_q[DATA_W-1:1]};
        if (last) begin
          if (rx_idx_q == IDX_LAST) begin
`ifdef UART_PARITY_EN
            rx_state_d = RX_PARITY;
`else
            rx_state_d = RX_STOP;
`endif
          end else begin
            rx_idx_d = rx_idx_q + 1'b1;
          end
        end
      end
      RX_PARITY: begin
        if (mid) perr_d = (line != ^shift_q);
        if (last) rx_state_d = RX_STOP;
      end
      RX_STOP: if (mid) begin
        rx_state_d = RX_IDLE;
        rx_cnt_d   = '0;
        if (line == STOP_LVL && !perr_q) begin
          data_d  = shift_q;
          ready_d = 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      data_q     <= '0;
      ready_q    <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      data_q     <= data_d;
      ready_q    <= ready_d;
    end
  end

  assign ready_rx = ready_q;
  assign data_rx  = data_q;

endmodule

// File: rtl/uart_link.sv
// UART TX with holding buffer, registered loopback line and receiver; UART_PARITY_EN adds even parity.
// Start bit on the line one cycle after ready_tx; ready_tx/write_tx ignored while a frame is in flight.
module uart_link
  import uart_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_tx,
  input  logic              ready_tx,
  input  logic              write_tx,
  output logic              ready_rx,
  output logic [DATA_W-1:0] data_rx
);

  localparam int CNT_W = clog2(CLKS_PER_BIT);
  localparam int IDX_W = clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  tx_state_e         tx_state_q, tx_state_d;
  logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
  logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic [IDX_W-1:0]  tx_idx_q, tx_idx_d;
  logic              line_q, line_d;
  logic              tx_last, tx_free;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_buf_d   = tx_buf_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_last    = (tx_cnt_q == CNT_LAST);
    // The final cycle of the stop bit counts as idle so frames can run back-to-back.
    tx_free    = (tx_state_q == TX_IDLE) || (tx_state_q == TX_STOP && tx_last);
    if (tx_state_q != TX_IDLE) tx_cnt_d = tx_last ? '0 : tx_cnt_q + 1'b1;
    case (tx_state_q)
      TX_START: if (tx_last) begin
        tx_state_d = TX_DATA;
        tx_idx_d   = '0;
      end
      TX_DATA: if (tx_last) begin
        if (tx_idx_q == IDX_LAST) begin
`ifdef UART_PARITY_EN
          tx_state_d = TX_PARITY;
`else
          tx_state_d = TX_STOP;
`endif
        end else begin
          tx_idx_d = tx_idx_q + 1'b1;
        end
      end
      TX_PARITY: if (tx_last) tx_state_d = TX_STOP;
      TX_STOP:   if (tx_last) tx_state_d = TX_IDLE;
      default: ;
    endcase
    if (tx_free) begin
      if (write_tx) tx_buf_d = data_tx;
      if (ready_tx) begin
        tx_state_d = TX_START;
        tx_cnt_d   = '0;
      end
    end
    // Line level follows the next state only, so it never depends on its own history.
    case (tx_state_d)
      TX_START:  line_d = START_LVL;
      TX_DATA:   line_d = tx_buf_d[tx_idx_d];
      TX_PARITY: line_d = ^tx_buf_d;
      TX_STOP:   line_d = STOP_LVL;
      default:   line_d = IDLE_LVL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_buf_q   <= '0;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      line_q     <= IDLE_LVL;
    end else begin
      tx_state_q <= tx_state_d;
      tx_buf_q   <= tx_buf_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      line_q     <= line_d;
    end
  end

  uart_link_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .DATA_W      (DATA_W)
  ) u_rx (
    .clk     (clk),
    .rst     (rst),
    .line    (line_q),
    .ready_rx(ready_rx),
    .data_rx (data_rx)
  );

endmodule

// File: tb/tb_uart_link.sv
// Directed bench for uart_link: one-clock-per-bit instance plus a four-clock-per-bit instance.
// Covers UART_PARITY_EN when that macro is defined for the build.
module tb_uart_link;

`ifdef UART_PARITY_EN
  localparam int   PAR_BITS  = 1;
  localparam logic FORCE_VAL = 1'b1;
  localparam logic [15:0] EXP_LINE = 16'h054A;
`else
  localparam int   PAR_BITS  = 0;
  localparam logic FORCE_VAL = 1'b0;
  localparam logic [15:0] EXP_LINE = 16'h074A;
`endif
  localparam int LAT1 = 10 + PAR_BITS;
  localparam int LAT4 = (9 + PAR_BITS) * 4 + 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_tx, data_tx4;
  logic       ready_tx, write_tx, ready_tx4, write_tx4;
  logic       ready_rx, ready_rx4;
  logic [7:0] data_rx, data_rx4;

  int checks = 0;
  int errors = 0;

  int         np, c1, c2;
  logic [7:0] d1, d2;
  logic [15:0] hist;

  always #5 clk = ~clk;

  uart_link #(.CLKS_PER_BIT(1), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .data_tx(data_tx), .ready_tx(ready_tx),
    .write_tx(write_tx), .ready_rx(ready_rx), .data_rx(data_rx)
  );

  uart_link #(.CLKS_PER_BIT(4), .DATA_W(8)) dut4 (
    .clk(clk), .rst(rst), .data_tx(data_tx4), .ready_tx(ready_tx4),
    .write_tx(write_tx4), .ready_rx(ready_rx4), .data_rx(data_rx4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_only(input logic [7:0] d);
    data_tx  = d;
    write_tx = 1'b1;
    @(negedge clk);
    write_tx = 1'b0;
  endtask

  // Returns after the edge that sampled ready_tx (observation point c=0).
  task automatic start_frame(input logic wr, input logic [7:0] d);
    data_tx  = d;
    write_tx = wr;
    ready_tx = 1'b1;
    @(negedge clk);
    write_tx = 1'b0;
    ready_tx = 1'b0;
  endtask

  task automatic watch(input int n, input int inj_c, input logic [7:0] inj_d,
                       output int npl, output int fc1, output logic [7:0] fd1,
                       output int fc2, output logic [7:0] fd2, output logic [15:0] lh);
    npl = 0; fc1 = -1; fc2 = -1; fd1 = '0; fd2 = '0; lh = '0;
    for (int c = 0; c <= n; c++) begin
      if (c > 0) begin
        @(negedge clk);
        write_tx = 1'b0;
        ready_tx = 1'b0;
      end
      if (c < 16) lh[c[3:0]] = dut.line_q;
      if (ready_rx) begin
        npl++;
        if (npl == 1) begin fc1 = c; fd1 = data_rx; end
        else begin fc2 = c; fd2 = data_rx; end
      end
      if (c == inj_c) begin
        data_tx  = inj_d;
        write_tx = 1'b1;
        ready_tx = 1'b1;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    data_tx = '0; write_tx = 1'b0; ready_tx = 1'b0;
    data_tx4 = '0; write_tx4 = 1'b0; ready_tx4 = 1'b0;
    #10;
    chk("rst_line", dut.line_q, 1'b1);
    chk("rst_ready_rx", ready_rx, 1'b0);
    chk("rst_data_rx", data_rx, 8'h00);
    chk("rst_line4", dut4.line_q, 1'b1);
    chk("rst_ready_rx4", ready_rx4, 1'b0);
    chk("rst_data_rx4", data_rx4, 8'h00);
    #8 rst = 1'b0;
    @(negedge clk);

    // Write then start on separate edges
    write_only(8'h4D);
    start_frame(1'b0, 8'h00);
    watch(LAT1 + 5, -1, 8'h00, np, c1, d1, c2, d2, hist);
    chk("t1_pulses", np, 1);
    chk("t1_latency", c1, LAT1);
    chk("t1_data", d1, 8'h4D);
    chk("t1_hold", data_rx, 8'h4D);

    // Same-edge write and start; line waveform
    start_frame(1'b1, 8'hA5);
    watch(LAT1 + 5, -1, 8'h00, np, c1, d1, c2, d2, hist);
    chk("t2_pulses", np, 1);
    chk("t2_latency", c1, LAT1);
    chk("t2_data", d1, 8'hA5);
    chk("t2_line", hist & 16'h07FF, EXP_LINE);

    // Write and start mid-frame are ignored
    start_frame(1'b1, 8'h3C);
    watch(LAT1 + 12, 4, 8'hFF, np, c1, d1, c2, d2, hist);
    chk("t3_pulses", np, 1);
    chk("t3_data", d1, 8'h3C);
    start_frame(1'b0, 8'h11);
    watch(LAT1 + 5, -1, 8'h00, np, c1, d1, c2, d2, hist);
    chk("t3_buf_kept_pulses", np, 1);
    chk("t3_buf_kept", d1, 8'h3C);

    // Back-to-back frames
    start_frame(1'b1, 8'h00);
    watch(2 * LAT1 + 4, LAT1 - 1, 8'hFF, np, c1, d1, c2, d2, hist);
    chk("t4_pulses", np, 2);
    chk("t4_lat1", c1, LAT1);
    chk("t4_data1", d1, 8'h00);
    chk("t4_lat2", c2, 2 * LAT1);
    chk("t4_data2", d2, 8'hFF);

    // Reset mid-frame
    start_frame(1'b1, 8'hC3);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_line", dut.line_q, 1'b1);
    chk("t5_ready_rx", ready_rx, 1'b0);
    chk("t5_data_rx", data_rx, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    watch(LAT1 + 5, -1, 8'h00, np, c1, d1, c2, d2, hist);
    chk("t5_no_pulse", np, 0);
    chk("t5_data_after", data_rx, 8'h00);
    start_frame(1'b0, 8'h77);
    watch(LAT1 + 5, -1, 8'h00, np, c1, d1, c2, d2, hist);
    chk("t5_zero_buf_pulses", np, 1);
    chk("t5_zero_buf", d1, 8'h00);

    // Four clocks per bit
    data_tx4 = 8'h4D; write_tx4 = 1'b1; ready_tx4 = 1'b1;
    @(negedge clk);
    write_tx4 = 1'b0; ready_tx4 = 1'b0;
    np = 0; c1 = -1; d1 = '0;
    for (int c = 1; c <= LAT4 + 8; c++) begin
      @(negedge clk);
      if (ready_rx4) begin
        np++;
        c1 = c;
        d1 = data_rx4;
      end
    end
    chk("t6_pulses", np, 1);
    chk("t6_latency", c1, LAT4);
    chk("t6_data", d1, 8'h4D);

    // Corrupt bit 9 (parity, or stop without parity) of a resend
    ready_tx4 = 1'b1;
    @(negedge clk);
    ready_tx4 = 1'b0;
    np = 0;
    for (int c = 1; c <= LAT4 + 8; c++) begin
      @(negedge clk);
      if (ready_rx4) np++;
      if (c == 37) force dut4.line_q = FORCE_VAL;
      if (c == 39) release dut4.line_q;
    end
    chk("t6_err_no_pulse", np, 0);
    chk("t6_err_data_kept", data_rx4, 8'h4D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
